// File: rtl/gs_sin_serializer.sv
// SIN/SCLK serializer for the LED-driver chain: one pixel bit per SCLK period, fetched from frame memory.
// Optional build macro GS_TEST_PATTERN_EN adds a test_mode input that replaces memory data with a chasing red LED.
`timescale 1ns/1ps

module gs_sin_serializer #(
    parameter int NB_ANGLES         = 128,
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int NB_ROWS           = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int SCLK_DIV          = 4,
    localparam int ANGLE_WIDTH      = $clog2(NB_ANGLES),
    localparam int LED_WIDTH        = $clog2(NB_LEDS_PER_GROUP),
    localparam int ADDR_WIDTH       = ANGLE_WIDTH + 2 + LED_WIDTH + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [ANGLE_WIDTH-1:0] angle,
    input  logic [NB_ROWS-1:0]     row_en,
    input  logic [LED_WIDTH-1:0]   led,
    input  logic [1:0]             color,
    input  logic [3:0]             bit_sel,
`ifdef GS_TEST_PATTERN_EN
    input  logic                   test_mode,
`endif
    output logic                   SCLK,
    output logic                   SIN,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   busy
);

    localparam int PH_W = $clog2(2 * SCLK_DIV);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * SCLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(SCLK_DIV);
    localparam logic [PH_W-1:0] PH_SHIFT = PH_W'(2);
    localparam logic [4:0] DW_LIM = 5'(DATA_WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns {valid, row}; the row being shifted is the one displayed after the current row_en.
    function automatic logic [2:0] decode_row(input logic [NB_ROWS-1:0] re);
        logic [2:0] r;
        r = 3'b000;
        if (re == '0) begin
            r = 3'b100;
        end else begin
            for (int i = 0; i < NB_ROWS - 1; i++) begin
                if (re == ({{(NB_ROWS-1){1'b0}}, 1'b1} << i)) begin
                    r = {1'b1, 2'(i + 1)};
                end
            end
        end
        return r;
    endfunction

    state_t          state_r, state_s;
    logic [PH_W-1:0] phase_r, phase_s;
    logic [2:0]      row_s;
    logic            fetch_s;
    logic            test_mode_s;
    logic            test_bit_s;
    logic            start_s;
    logic            shift_s;

    logic             sclk_r;
    logic             sin_r;
    logic             rd_en_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic             busy_r;
    logic             pad_r;
    logic             test_sel_r;
    logic             test_bit_r;
    logic [IDX_W-1:0] bit_idx_r;

`ifdef GS_TEST_PATTERN_EN
    assign test_mode_s = test_mode;
`else
    assign test_mode_s = 1'b0;
`endif

    // Next-state and phase counter; a started period always runs to its last phase.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        case (state_r)
            IDLE: begin
                phase_s = '0;
                if (enable && (phase_r == '0)) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (phase_r == PH_LAST) begin
                    phase_s = '0;
                    if (enable) begin
                        state_s = RUN;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    phase_s = phase_r + {{(PH_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                phase_s = '0;
            end
        endcase
    end

    // Fetch qualification and pattern pixel derived from the fields sampled at period start.
    always_comb begin
        row_s      = decode_row(row_en);
        fetch_s    = row_s[2] && ({1'b0, bit_sel} < DW_LIM);
        test_bit_s = (color == 2'd0) && (led == angle[LED_WIDTH-1:0]);
        start_s    = (state_s == RUN) && (phase_s == '0);
        shift_s    = (state_s == RUN) && (phase_s == PH_SHIFT);
    end

    // State, phase and the SCLK/busy outputs, registered so they align with the phase count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            phase_r <= '0;
            sclk_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            sclk_r  <= (state_s == RUN) && (phase_s >= PH_HIGH);
            busy_r  <= (state_s == RUN);
        end
    end

    // Period-start sampling: memory read strobe/address and the per-period padding decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_r    <= 1'b0;
            addr_r     <= '0;
            pad_r      <= 1'b0;
            test_sel_r <= 1'b0;
            test_bit_r <= 1'b0;
            bit_idx_r  <= '0;
        end else if (start_s) begin
            rd_en_r    <= fetch_s && !test_mode_s;
            pad_r      <= !fetch_s;
            test_sel_r <= test_mode_s;
            test_bit_r <= test_bit_s;
            bit_idx_r  <= bit_sel[IDX_W-1:0];
            if (fetch_s && !test_mode_s) begin
                addr_r <= {angle, row_s[1:0], led, color};
            end else begin
                addr_r <= addr_r;
            end
        end else begin
            rd_en_r <= 1'b0;
        end
    end

    // SIN update two clocks into the period, once the read data has returned; held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sin_r <= 1'b0;
        end else if (shift_s) begin
            if (pad_r) begin
                sin_r <= 1'b0;
            end else if (test_sel_r) begin
                sin_r <= test_bit_r;
            end else begin
                sin_r <= mem_rdata[bit_idx_r];
            end
        end else begin
            sin_r <= sin_r;
        end
    end

    assign SCLK      = sclk_r;
    assign SIN       = sin_r;
    assign mem_rd_en = rd_en_r;
    assign mem_addr  = addr_r;
    assign busy      = busy_r;

endmodule
